// File: rtl/rs232_tx_feeder.sv
// rs232_tx_feeder: byte FIFO feeding an RS-232 transmitter through its
// send/sending handshake. One byte is launched at a time. A new launch only
// happens in IDLE while the transmitter reports not-sending, so the
// transmitter can never be overrun. Host-side drops and missing send
// acknowledgements are reported through sticky flags.
//
// Handshake (tx side): tx_send is a one-cycle registered pulse issued from
// LAUNCH. tx_data is valid in that cycle and is held until the next pop. The
// transmitter is expected to raise tx_sending within START_TIMEOUT+1 cycles
// after the pulse and to hold it high for the whole frame.
`timescale 1ns/1ps
module rs232_tx_feeder #(
  parameter int AW            = 4,
  parameter int START_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  input  logic          flush,
  input  logic          ovf_clr,
  output logic          wr_ovf,
  output logic          start_err,
  output logic [7:0]    tx_data,
  output logic          tx_send,
  input  logic          tx_sending,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [3:0]  TMO_LOAD = 4'(START_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LAUNCH     = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            wr_ovf_q, wr_ovf_d;
  logic            start_err_q, start_err_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_send_q, tx_send_d;
  logic [3:0]      tmo_q, tmo_d;
  logic            start_err_set;
  logic [7:0]      mem [DEPTH];

  logic full_w;
  logic wr_accept;
  logic pop;

  // Full is taken from the registered count, so a write in the same cycle as
  // a pop from a full FIFO is still rejected. Flush wins over both ports.
  assign full_w    = (count_q == FULL_CNT);
  assign wr_accept = wr_en && !full_w && !flush;
  assign pop       = (state_q == IDLE) && (count_q != '0) && !tx_sending && !flush;

  // Launch sequencer: next state, timeout counter and the byte to present.
  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    tx_data_d     = tx_data_q;
    start_err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d   = LAUNCH;
          tx_data_d = mem[rd_ptr_q];
        end
      end
      LAUNCH: begin
        tmo_d   = TMO_LOAD;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (tx_sending) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == '0) begin
          start_err_set = 1'b1;
          state_d       = IDLE;
        end else begin
          tmo_d = tmo_q - 4'd1;
        end
      end
      WAIT_DONE: begin
        if (!tx_sending) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    tx_send_d = (state_d == LAUNCH);
  end

  // FIFO pointers, occupancy and sticky flags (set has priority over clear).
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wr_ovf_d    = (wr_ovf_q && !ovf_clr) || (wr_en && full_w && !flush);
    start_err_d = (start_err_q && !ovf_clr) || start_err_set;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)       rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_accept, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ovf_q    <= 1'b0;
      start_err_q <= 1'b0;
      tx_data_q   <= '0;
      tx_send_q   <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ovf_q    <= wr_ovf_d;
      start_err_q <= start_err_d;
      tx_data_q   <= tx_data_d;
      tx_send_q   <= tx_send_d;
      tmo_q       <= tmo_d;
    end
  end

  // Storage array; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_q] <= wr_data;
  end

  assign full      = full_w;
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign wr_ovf    = wr_ovf_q;
  assign start_err = start_err_q;
  assign tx_data   = tx_data_q;
  assign tx_send   = tx_send_q;
  assign busy      = (state_q != IDLE) || (count_q != '0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rs232_tx_feeder.sv
// Directed bench for rs232_tx_feeder. A transmitter stub answers each send
// (normal frame, silent, or externally held busy) and a scoreboard checks
// every launched byte against the expected queue and the launch protocol.
`timescale 1ns/1ps
module tb_rs232_tx_feeder;

  localparam int AW    = 4;
  localparam int FRAME = 12;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_LAUNCH = 2'd1,
                         ST_WSTART = 2'd2, ST_WDONE = 2'd3;

  logic        clk = 1'b0;
  logic        reset, wr_en, flush, ovf_clr, tx_sending;
  logic [7:0]  wr_data;
  logic        full, empty, wr_ovf, start_err, tx_send, busy;
  logic [AW:0] count;
  logic [7:0]  tx_data;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int send_count = 0;
  int stub_mode;            // 0 normal frame, 1 silent, 2 follow ext_sending
  logic ext_sending;
  logic pending;
  int remaining;
  logic prev_send, prev_sending;
  logic [7:0] sb_exp;
  logic [7:0] exp_q[$];

  rs232_tx_feeder #(.AW(AW), .START_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .count(count), .flush(flush),
    .ovf_clr(ovf_clr), .wr_ovf(wr_ovf), .start_err(start_err),
    .tx_data(tx_data), .tx_send(tx_send), .tx_sending(tx_sending),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic write_byte(input logic [7:0] b, input bit emit);
    wr_en = 1'b1;
    wr_data = b;
    if (emit) exp_q.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while ((busy || tx_sending) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy || tx_sending) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy=%b tx_sending=%b after %0d cycles, required 0/0", tag, busy, tx_sending, n);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d, required 0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rst_flags: empty=%b full=%b, required 1/0", empty, full); end
    checks++; if (tx_send !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx: send=%b data=%h, required 0/00", tx_send, tx_data); end
    checks++; if (wr_ovf !== 1'b0 || start_err !== 1'b0) begin errors++; $display("FAIL rst_sticky: ovf=%b err=%b, required 0/0", wr_ovf, start_err); end
    checks++; if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: busy=%b state=%0d, required 0/0", busy, dbg_state); end
  endtask

  task automatic test_single();
    int n;
    write_byte(8'hA5, 1'b1);
    checks++; if (count !== 5'd1 || tx_send !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_c1: count=%0d send=%b busy=%b, required 1/0/1", count, tx_send, busy); end
    @(negedge clk);
    checks++; if (tx_send !== 1'b1 || tx_data !== 8'hA5 || dbg_state !== ST_LAUNCH) begin errors++; $display("FAIL single_c2: send=%b data=%h state=%0d, required 1/a5/1", tx_send, tx_data, dbg_state); end
    @(negedge clk);
    checks++; if (tx_send !== 1'b0 || tx_data !== 8'hA5 || dbg_state !== ST_WSTART) begin errors++; $display("FAIL single_c3: send=%b data=%h state=%0d, required 0/a5/2", tx_send, tx_data, dbg_state); end
    n = 0;
    while (tx_sending && n < 100) begin @(negedge clk); n++; end
    checks++; if (tx_sending !== 1'b0 || busy !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL single_done: sending=%b busy=%b data=%h, required 0/1/a5", tx_sending, busy, tx_data); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL single_idle: busy=%b state=%0d, required 0/0", busy, dbg_state); end
  endtask

  task automatic test_burst();
    int s0;
    s0 = send_count;
    stub_mode = 2; ext_sending = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); exp_q.push_back(8'(i));
      @(negedge clk);
    end
    checks++; if (count !== 5'd16 || full !== 1'b1 || wr_ovf !== 1'b0) begin errors++; $display("FAIL burst_full: count=%0d full=%b ovf=%b, required 16/1/0", count, full, wr_ovf); end
    wr_data = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    checks++; if (count !== 5'd16 || wr_ovf !== 1'b1) begin errors++; $display("FAIL burst_ovf: count=%0d ovf=%b, required 16/1", count, wr_ovf); end
    stub_mode = 0;
    wait_idle(600, "burst");
    checks++; if (exp_q.size() != 0 || send_count - s0 != 16) begin errors++; $display("FAIL burst_drain: left=%0d sends=%0d, required 0/16", exp_q.size(), send_count - s0); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++; if (wr_ovf !== 1'b0) begin errors++; $display("FAIL burst_ovf_clr: ovf=%b, required 0", wr_ovf); end
  endtask

  task automatic test_concurrent_wrap();
    int s0;
    s0 = send_count;
    stub_mode = 2; ext_sending = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) write_byte(8'h40 + 8'(i), 1'b1);
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL conc_pre: count=%0d, required 3", count); end
    stub_mode = 0;
    @(negedge clk);
    write_byte(8'h43, 1'b1);   // lands on the same edge as the first pop
    checks++; if (count !== 5'd3 || tx_send !== 1'b1 || tx_data !== 8'h40) begin errors++; $display("FAIL conc_same_edge: count=%0d send=%b data=%h, required 3/1/40", count, tx_send, tx_data); end
    for (int i = 4; i < 20; i++) begin
      repeat (5) @(negedge clk);
      write_byte(8'h40 + 8'(i), 1'b1);
    end
    wait_idle(800, "wrap");
    checks++; if (exp_q.size() != 0 || send_count - s0 != 20 || wr_ovf !== 1'b0) begin errors++; $display("FAIL wrap_drain: left=%0d sends=%0d ovf=%b, required 0/20/0", exp_q.size(), send_count - s0, wr_ovf); end
  endtask

  task automatic test_timeout();
    int n, k;
    stub_mode = 1;
    @(negedge clk);
    write_byte(8'hC1, 1'b1);
    write_byte(8'hC2, 1'b1);
    n = 0;
    while (!tx_send && n < 10) begin @(negedge clk); n++; end
    k = 0;
    while (!start_err && k < 40) begin @(negedge clk); k++; end
    // 1 send cycle + 16 WAIT_START cycles (START_TIMEOUT+1), flag visible after
    checks++; if (k != 17 || n != 0) begin errors++; $display("FAIL tmo_latency: send_wait=%0d err_after=%0d, required 0/17", n, k); end
    checks++; if (dbg_state !== ST_IDLE || count !== 5'd1) begin errors++; $display("FAIL tmo_idle: state=%0d count=%0d, required 0/1", dbg_state, count); end
    @(negedge clk);
    checks++; if (tx_send !== 1'b1 || tx_data !== 8'hC2) begin errors++; $display("FAIL tmo_next: send=%b data=%h, required 1/c2", tx_send, tx_data); end
    wait_idle(60, "tmo");
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++; if (start_err !== 1'b0) begin errors++; $display("FAIL tmo_clr: start_err=%b, required 0", start_err); end
    stub_mode = 0;
    @(negedge clk);
  endtask

  task automatic test_ext_hold();
    bit saw;
    stub_mode = 2; ext_sending = 1'b1;
    repeat (2) @(negedge clk);
    write_byte(8'hD1, 1'b1);
    write_byte(8'hD2, 1'b1);
    saw = 1'b0;
    repeat (6) begin @(negedge clk); if (tx_send) saw = 1'b1; end
    checks++; if (saw || count !== 5'd2) begin errors++; $display("FAIL hold_block: saw_send=%b count=%0d, required 0/2", saw, count); end
    stub_mode = 0;
    @(negedge clk);
    checks++; if (tx_sending !== 1'b0 || tx_send !== 1'b0) begin errors++; $display("FAIL hold_drop: sending=%b send=%b, required 0/0", tx_sending, tx_send); end
    @(negedge clk);
    checks++; if (tx_send !== 1'b1 || tx_data !== 8'hD1) begin errors++; $display("FAIL hold_launch: send=%b data=%h, required 1/d1", tx_send, tx_data); end
    wait_idle(100, "hold");
  endtask

  task automatic test_flush();
    int s0;
    s0 = send_count;
    write_byte(8'hE0, 1'b1);
    for (int i = 1; i < 6; i++) write_byte(8'hE0 + 8'(i), 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (dbg_state !== ST_WDONE || count !== 5'd5) begin errors++; $display("FAIL flush_pre: state=%0d count=%0d, required 3/5", dbg_state, count); end
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
    @(negedge clk);
    flush = 1'b0; wr_en = 1'b0;
    checks++; if (count !== 5'd0 || empty !== 1'b1 || tx_data !== 8'hE0 || dbg_state !== ST_WDONE) begin errors++; $display("FAIL flush_post: count=%0d empty=%b data=%h state=%0d, required 0/1/e0/3", count, empty, tx_data, dbg_state); end
    wait_idle(100, "flush");
    checks++; if (send_count - s0 != 1 || exp_q.size() != 0) begin errors++; $display("FAIL flush_sends: sends=%0d left=%0d, required 1/0", send_count - s0, exp_q.size()); end
  endtask

  task automatic test_reset_in_launch();
    write_byte(8'hF7, 1'b1);
    @(negedge clk);
    checks++; if (tx_send !== 1'b1 || dbg_state !== ST_LAUNCH) begin errors++; $display("FAIL rl_launch: send=%b state=%0d, required 1/1", tx_send, dbg_state); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (tx_send !== 1'b0 || dbg_state !== ST_IDLE || tx_data !== 8'h00) begin errors++; $display("FAIL rl_after: send=%b state=%0d data=%h, required 0/0/00", tx_send, dbg_state, tx_data); end
    write_byte(8'hF8, 1'b1);
    repeat (2) @(negedge clk);
    checks++; if (tx_send !== 1'b0 || count !== 5'd1 || tx_sending !== 1'b1) begin errors++; $display("FAIL rl_wait: send=%b count=%0d sending=%b, required 0/1/1", tx_send, count, tx_sending); end
    wait_idle(100, "rl");
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rl_drain: left=%0d, required 0", exp_q.size()); end
  endtask

  // ---------------- main sequence, stub and scoreboard ----------------
  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; ovf_clr = 1'b0;
    tx_sending = 1'b0; stub_mode = 0; ext_sending = 1'b0; pending = 1'b0;
    remaining = 0; prev_send = 1'b0; prev_sending = 1'b0; sb_exp = 8'h00;
    fork
      forever begin
        @(posedge clk);
        #1;
        if (tx_send) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: tx_data=%h launched, required no launch", tx_data);
          end else begin
            sb_exp = exp_q.pop_front();
            if (tx_data !== sb_exp) begin
              errors++;
              $display("FAIL sb_byte: tx_data=%h, required %h", tx_data, sb_exp);
            end
          end
          checks++;
          if (prev_send || prev_sending) begin
            errors++;
            $display("FAIL send_protocol: prev_send=%b prev_sending=%b, required 0/0", prev_send, prev_sending);
          end
          send_count++;
        end
        prev_send = tx_send;
        case (stub_mode)
          0: begin
            if (pending) begin
              tx_sending = 1'b1; remaining = FRAME; pending = 1'b0;
            end else if (remaining > 0) begin
              remaining--;
              if (remaining == 0) tx_sending = 1'b0;
            end else begin
              tx_sending = 1'b0;
            end
          end
          1: tx_sending = 1'b0;
          default: tx_sending = ext_sending;
        endcase
        if (tx_send && stub_mode == 0) pending = 1'b1;
        prev_sending = tx_sending;
      end
    join_none

    @(negedge clk);
    test_reset();
    test_single();
    test_burst();
    test_concurrent_wrap();
    test_timeout();
    test_ext_hold();
    test_flush();
    test_reset_in_launch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
